// File: rtl/stream_packet_arbiter.sv
// Packet-atomic two-input round-robin arbiter onto one 32-bit stream.
// Overlong packets are cut at MAX_BEATS, flagged, and their tail dropped.
module stream_packet_arbiter #(
  parameter int MAX_BEATS = 512,
  parameter int CW        = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sink0_valid,
  output logic        sink0_ready,
  input  logic        sink0_first,
  input  logic        sink0_last,
  input  logic [31:0] sink0_payload_data,
  input  logic [3:0]  sink0_payload_last_be,
  input  logic [3:0]  sink0_payload_error,
  input  logic        sink1_valid,
  output logic        sink1_ready,
  input  logic        sink1_first,
  input  logic        sink1_last,
  input  logic [31:0] sink1_payload_data,
  input  logic [3:0]  sink1_payload_last_be,
  input  logic [3:0]  sink1_payload_error,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_first,
  output logic        source_last,
  output logic [31:0] source_payload_data,
  output logic [3:0]  source_payload_last_be,
  output logic [3:0]  source_payload_error,
  output logic [1:0]  grant,
  output logic        trunc_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    DROP
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] beat_cnt, cnt_nx;
  logic          last_grant, lg_nx;
  logic          owner, owner_nx;
  logic          trunc_nx;

  logic          sel;
  logic          g_valid, g_last;
  logic [31:0]   g_data;
  logic [3:0]    g_be, g_err;
  logic          at_max;
  logic          unused_first;

  // Framing is regenerated from beat_cnt, so incoming first flags are ignored.
  assign unused_first = sink0_first ^ sink1_first;

  // Selected sink: the granted port, or the port being drained.
  assign sel = (state == GRANT1) || ((state == DROP) && owner);
  assign g_valid = sel ? sink1_valid : sink0_valid;
  assign g_last  = sel ? sink1_last : sink0_last;
  assign g_data  = sel ? sink1_payload_data : sink0_payload_data;
  assign g_be    = sel ? sink1_payload_last_be : sink0_payload_last_be;
  assign g_err   = sel ? sink1_payload_error : sink0_payload_error;
  assign at_max  = (beat_cnt == CNT_MAX);

  assign grant = {state == GRANT1, state == GRANT0};

  // Arbitration, pass-through mux and truncation decisions.
  always_comb begin
    state_nx               = state;
    cnt_nx                 = beat_cnt;
    lg_nx                  = last_grant;
    owner_nx               = owner;
    trunc_nx               = 1'b0;
    sink0_ready            = 1'b0;
    sink1_ready            = 1'b0;
    source_valid           = 1'b0;
    source_first           = 1'b0;
    source_last            = 1'b0;
    source_payload_data    = '0;
    source_payload_last_be = '0;
    source_payload_error   = '0;
    unique case (state)
      IDLE: begin
        if (sink0_valid && (!sink1_valid || last_grant)) begin
          state_nx = GRANT0;
          lg_nx    = 1'b0;
          cnt_nx   = '0;
        end else if (sink1_valid) begin
          state_nx = GRANT1;
          lg_nx    = 1'b1;
          cnt_nx   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (sel) sink1_ready = source_ready;
        else     sink0_ready = source_ready;
        source_valid        = g_valid;
        source_first        = (beat_cnt == '0);
        source_last         = g_last || at_max;
        source_payload_data = g_data;
        source_payload_last_be =
          (at_max && !g_last) ? 4'hF : g_be;
        source_payload_error =
          (at_max && !g_last) ? 4'hF : g_err;
        if (g_valid && source_ready) begin
          if (!at_max) cnt_nx = beat_cnt + CW'(1);
          if (g_last) begin
            state_nx = IDLE;
          end else if (at_max) begin
            state_nx = DROP;
            owner_nx = sel;
            trunc_nx = 1'b1;
          end
        end
      end
      DROP: begin
        if (owner) sink1_ready = 1'b1;
        else       sink0_ready = 1'b1;
        if (g_valid && g_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter and round-robin pointer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      beat_cnt    <= cnt_nx;
      last_grant  <= lg_nx;
      owner       <= owner_nx;
      trunc_pulse <= trunc_nx;
    end
  end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Bench for stream_packet_arbiter: vector tables, directed corner
// sequences and a randomized run against a packet-level model.
module tb_stream_packet_arbiter;

  localparam int MB = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        v [2];
  logic        f [2];
  logic        l [2];
  logic [31:0] d [2];
  logic [3:0]  be [2];
  logic [3:0]  er [2];
  logic        r0, r1;
  logic        source_valid, source_ready;
  logic        source_first, source_last;
  logic [31:0] source_payload_data;
  logic [3:0]  source_payload_last_be, source_payload_error;
  logic [1:0]  grant;
  logic        trunc_pulse;

  stream_packet_arbiter #(.MAX_BEATS(MB), .CW(4)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .sink0_valid(v[0]),
    .sink0_ready(r0),
    .sink0_first(f[0]),
    .sink0_last(l[0]),
    .sink0_payload_data(d[0]),
    .sink0_payload_last_be(be[0]),
    .sink0_payload_error(er[0]),
    .sink1_valid(v[1]),
    .sink1_ready(r1),
    .sink1_first(f[1]),
    .sink1_last(l[1]),
    .sink1_payload_data(d[1]),
    .sink1_payload_last_be(be[1]),
    .sink1_payload_error(er[1]),
    .source_valid(source_valid),
    .source_ready(source_ready),
    .source_first(source_first),
    .source_last(source_last),
    .source_payload_data(source_payload_data),
    .source_payload_last_be(source_payload_last_be),
    .source_payload_error(source_payload_error),
    .grant(grant),
    .trunc_pulse(trunc_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int plen [2][$];
  int pk [2];
  int pb [2];
  int vpct = 100;

  typedef struct {
    logic        rdy;
    logic        sv;
    logic [31:0] data;
    logic        first;
    logic        last;
    logic [1:0]  g;
    logic        rr0;
    logic        rr1;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
    logic [3:0]  be;
    logic [3:0]  er;
  } beat_t;

  vec_t  tab [$];
  beat_t expq [$];

  function automatic logic [31:0] dat(int s, int p, int b);
    logic [7:0] base;
    logic [7:0] pp;
    logic [7:0] bb;
    base = (s == 1) ? 8'hB0 : 8'hA0;
    pp = p[7:0];
    bb = b[7:0];
    return {pp, 16'h0, base + bb};
  endfunction

  function automatic logic [3:0] fbe(int s, int p, int b);
    return 4'(p + b + s + 1);
  endfunction

  function automatic logic [3:0] ferr(int s, int p, int b);
    return (b == 1 && p % 2 == 1) ? 4'(5 + s) : 4'h0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Present the current beat of each producer's packet list.
  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      if (pk[s] < plen[s].size()) begin
        int ln;
        ln = plen[s][pk[s]];
        v[s]  = (pb[s] == 0) || ($urandom_range(99) < vpct);
        f[s]  = (pb[s] == 0);
        l[s]  = (pb[s] == ln - 1);
        d[s]  = dat(s, pk[s], pb[s]);
        be[s] = fbe(s, pk[s], pb[s]);
        er[s] = ferr(s, pk[s], pb[s]);
      end else begin
        v[s] = 1'b0; f[s] = 1'b0; l[s] = 1'b0;
        d[s] = '0; be[s] = '0; er[s] = '0;
      end
    end
  endtask

  task automatic adv(int s, logic fire);
    if (fire) begin
      pb[s]++;
      if (pb[s] == plen[s][pk[s]]) begin
        pk[s]++;
        pb[s] = 0;
      end
    end
  endtask

  // Called at the negedge after checks; returns at posedge+1 with new inputs.
  task automatic cycle_end();
    logic fr0, fr1;
    fr0 = v[0] && r0;
    fr1 = v[1] && r1;
    @(posedge sys_clk);
    #1;
    adv(0, fr0);
    adv(1, fr1);
    drive();
  endtask

  task automatic setup(int n0, int n1, int len0, int len1);
    plen[0].delete();
    plen[1].delete();
    for (int i = 0; i < n0; i++) plen[0].push_back(len0);
    for (int i = 0; i < n1; i++) plen[1].push_back(len1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    pk[0] = 0; pk[1] = 0; pb[0] = 0; pb[1] = 0;
    drive();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_tab(string nm);
    for (int i = 0; i < tab.size(); i++) begin
      source_ready = tab[i].rdy;
      @(negedge sys_clk);
      chk($sformatf("%s%0d.sv", nm, i), 64'(source_valid), 64'(tab[i].sv));
      chk($sformatf("%s%0d.grant", nm, i), 64'(grant), 64'(tab[i].g));
      chk($sformatf("%s%0d.rdy", nm, i), 64'({r0, r1}),
          64'({tab[i].rr0, tab[i].rr1}));
      if (tab[i].sv) begin
        chk($sformatf("%s%0d.data", nm, i), 64'(source_payload_data),
            64'(tab[i].data));
        chk($sformatf("%s%0d.fl", nm, i), 64'({source_first, source_last}),
            64'({tab[i].first, tab[i].last}));
      end
      cycle_end();
    end
  endtask

  int ntr;
  int ntr_exp;
  int viol;
  int cyc;
  beat_t got;
  beat_t want;

  initial begin
    source_ready = 1'b1;
    sys_rst_n = 1'b0;
    pk[0] = 0; pk[1] = 0; pb[0] = 0; pb[1] = 0;

    // Reset behaviour with both sinks valid.
    setup(4, 4, 3, 3);
    drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("rst.ready", 64'({r0, r1}), 64'(0));
      chk("rst.sv", 64'(source_valid), 64'(0));
      chk("rst.grant", 64'(grant), 64'(0));
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Alternation of continuous 3-beat packets.
    tab.delete();
    tab.push_back('{1, 0, 0, 0, 0, 2'b00, 0, 0});
    tab.push_back('{1, 1, 32'h000000A0, 1, 0, 2'b01, 1, 0});
    tab.push_back('{1, 1, 32'h000000A1, 0, 0, 2'b01, 1, 0});
    tab.push_back('{1, 1, 32'h000000A2, 0, 1, 2'b01, 1, 0});
    tab.push_back('{1, 0, 0, 0, 0, 2'b00, 0, 0});
    tab.push_back('{1, 1, 32'h000000B0, 1, 0, 2'b10, 0, 1});
    tab.push_back('{1, 1, 32'h000000B1, 0, 0, 2'b10, 0, 1});
    tab.push_back('{1, 1, 32'h000000B2, 0, 1, 2'b10, 0, 1});
    tab.push_back('{1, 0, 0, 0, 0, 2'b00, 0, 0});
    tab.push_back('{1, 1, 32'h010000A0, 1, 0, 2'b01, 1, 0});
    tab.push_back('{1, 1, 32'h010000A1, 0, 0, 2'b01, 1, 0});
    run_tab("alt");

    // Backpressure on a 4-beat packet from sink1.
    setup(0, 1, 0, 4);
    do_reset();
    tab.delete();
    tab.push_back('{1, 0, 0, 0, 0, 2'b00, 0, 0});
    tab.push_back('{0, 1, 32'h000000B0, 1, 0, 2'b10, 0, 0});
    tab.push_back('{1, 1, 32'h000000B0, 1, 0, 2'b10, 0, 1});
    tab.push_back('{0, 1, 32'h000000B1, 0, 0, 2'b10, 0, 0});
    tab.push_back('{1, 1, 32'h000000B1, 0, 0, 2'b10, 0, 1});
    tab.push_back('{0, 1, 32'h000000B2, 0, 0, 2'b10, 0, 0});
    tab.push_back('{1, 1, 32'h000000B2, 0, 0, 2'b10, 0, 1});
    tab.push_back('{0, 1, 32'h000000B3, 0, 1, 2'b10, 0, 0});
    tab.push_back('{1, 1, 32'h000000B3, 0, 1, 2'b10, 0, 1});
    tab.push_back('{0, 0, 0, 0, 0, 2'b00, 0, 0});
    run_tab("bp");

    // Truncation: 7-beat packet from sink0.
    source_ready = 1'b1;
    setup(1, 0, 7, 0);
    do_reset();
    @(negedge sys_clk);
    chk("tr.idle.sv", 64'(source_valid), 64'(0));
    cycle_end();
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk($sformatf("tr.b%0d", i),
          {source_valid, source_last, source_payload_data},
          {1'b1, 1'b0, dat(0, 0, i)});
      chk("tr.pulse0", 64'(trunc_pulse), 64'(0));
      cycle_end();
    end
    @(negedge sys_clk);
    chk("tr.cut", {source_valid, source_last, source_payload_error,
                   source_payload_last_be, source_payload_data},
        {1'b1, 1'b1, 4'hF, 4'hF, dat(0, 0, 3)});
    cycle_end();
    @(negedge sys_clk);
    chk("tr.pulse", 64'(trunc_pulse), 64'(1));
    chk("tr.drop", 64'({source_valid, r0, r1, grant}), 64'(5'b01000));
    cycle_end();
    @(negedge sys_clk);
    chk("tr.pulse_end", 64'(trunc_pulse), 64'(0));
    chk("tr.drop2", 64'({source_valid, r0}), 64'(2'b01));
    cycle_end();
    @(negedge sys_clk);
    chk("tr.drop3", 64'({source_valid, r0}), 64'(2'b01));
    cycle_end();
    @(negedge sys_clk);
    chk("tr.idle", 64'({source_valid, r0, grant}), 64'(0));
    chk("tr.consumed", 64'(pk[0]), 64'(1));

    // Boundary length: exactly MB beats from sink1.
    cycle_end();
    setup(0, 1, 0, MB);
    do_reset();
    @(negedge sys_clk);
    cycle_end();
    for (int i = 0; i < MB; i++) begin
      @(negedge sys_clk);
      chk($sformatf("bd.b%0d", i),
          {source_valid, source_last, source_payload_error,
           source_payload_last_be, source_payload_data},
          {1'b1, i == MB - 1, ferr(1, 0, i), fbe(1, 0, i), dat(1, 0, i)});
      cycle_end();
    end
    @(negedge sys_clk);
    chk("bd.nopulse", 64'({trunc_pulse, source_valid, grant}), 64'(0));

    // Reset in the middle of a packet from sink0 while sink1 waits.
    cycle_end();
    setup(1, 1, 5, 3);
    do_reset();
    @(negedge sys_clk);
    cycle_end();
    @(negedge sys_clk);
    cycle_end();
    @(negedge sys_clk);
    chk("rm.b2", {source_valid, source_payload_data}, {1'b1, dat(0, 0, 1)});
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("rm.cut", 64'({source_valid, r0, r1, grant}), 64'(0));
    pk[0] = 0; pk[1] = 0; pb[0] = 0; pb[1] = 0;
    @(posedge sys_clk);
    #1;
    drive();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rm.idle", 64'(source_valid), 64'(0));
    cycle_end();
    @(negedge sys_clk);
    chk("rm.regrant", {grant, source_payload_data}, {2'b01, dat(0, 0, 0)});

    // Randomized run against a packet-level model.
    cycle_end();
    plen[0].delete();
    plen[1].delete();
    for (int i = 0; i < 10; i++) begin
      plen[0].push_back(int'($urandom_range(7, 1)));
      plen[1].push_back(int'($urandom_range(7, 1)));
    end
    expq.delete();
    ntr_exp = 0;
    for (int k = 0; k < 20; k++) begin
      int s, p, ln, n;
      s = k % 2;
      p = k / 2;
      ln = plen[s][p];
      n = (ln > MB) ? MB : ln;
      if (ln > MB) ntr_exp++;
      for (int b = 0; b < n; b++) begin
        logic cut;
        cut = (ln > MB) && (b == MB - 1);
        expq.push_back('{dat(s, p, b), b == 0, b == n - 1,
                         cut ? 4'hF : fbe(s, p, b),
                         cut ? 4'hF : ferr(s, p, b)});
      end
    end
    vpct = 75;
    do_reset();
    ntr = 0;
    viol = 0;
    cyc = 0;
    while (expq.size() > 0 && cyc < 3000) begin
      source_ready = ($urandom_range(99) < 70);
      @(negedge sys_clk);
      if (trunc_pulse) ntr++;
      if (r0 && r1) viol++;
      if (source_valid && source_ready) begin
        got = '{source_payload_data, source_first, source_last,
                source_payload_last_be, source_payload_error};
        want = expq.pop_front();
        chk("rnd.beat", 64'(got), 64'(want));
      end
      cycle_end();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (trunc_pulse) ntr++;
      if (source_valid) viol++;
      cycle_end();
    end
    chk("rnd.left", 64'(expq.size()), 64'(0));
    chk("rnd.trunc", 64'(ntr), 64'(ntr_exp));
    chk("rnd.viol", 64'(viol), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_packet_arbiter.md
# stream_packet_arbiter

Two-input, packet-atomic round-robin arbiter that shares one 32-bit packet stream sink, the anti-underflow stage in the MAC TX path, between two packet producers. A grant is held from the first beat of a packet through its `last` beat, so packets are never interleaved. A per-packet beat limit guards against a stuck producer: an overlong packet is truncated, marked in error, and its remainder is discarded.

## Interface
Parameters
- `MAX_BEATS`, default 512: maximum number of beats forwarded per packet. Legal range 2..65535.
- `CW`, default 16: beat counter width. Must satisfy `2^CW > MAX_BEATS`.

Ports
- `sys_clk` in 1: system clock. All logic is on the rising edge.
- `sys_rst_n` in 1: reset, asynchronous assertion, active-low.
- `sinkN_valid` in 1, N = 0, 1: requester N beat valid.
- `sinkN_ready` out 1: requester N beat accepted.
- `sinkN_first`, `sinkN_last` in 1 each: packet framing.
- `sinkN_payload_data` in 32: beat data.
- `sinkN_payload_last_be` in 4: byte enables, meaningful on the last beat.
- `sinkN_payload_error` in 4: per-byte error flags.
- `source_valid` out 1, `source_ready` in 1: shared output handshake.
- `source_first`, `source_last` out 1 each: output framing.
- `source_payload_data` out 32, `source_payload_last_be` out 4, `source_payload_error` out 4: output payload.
- `grant` out 2: one-hot owner of the source. 00 means idle or dropping.
- `trunc_pulse` out 1: one-cycle pulse when a packet is truncated.

## Operation
- A beat transfers on a port when that port's valid and ready are both 1 on a rising edge.
- States: IDLE, GRANT0, GRANT1, DROP. `owner` (1 bit) records the port that DROP is draining.
- Round-robin pointer `last_grant` holds the last port that was granted. It resets to 1, so port 0 wins the first tie.

IDLE
- All readies are 0. `source_valid` is 0.
- Only sink0 valid: go to GRANT0.
- Only sink1 valid: go to GRANT1.
- Both valid: grant the port not equal to `last_grant`.
- On any grant: update `last_grant` and clear `beat_cnt`.

GRANTn
- Source outputs are a combinational mux of sinkn.
- `sinkn_ready = source_ready`. The other sink's ready is 0.
- `source_first` is 1 when `beat_cnt == 0`. It is generated here; `sinkn_first` is ignored.
- Each transferred beat increments `beat_cnt`.
- Transfer with `sinkn_last = 1`: go to IDLE.
- Transfer when `beat_cnt == MAX_BEATS-1` and `sinkn_last = 0` (truncation):
  - That beat is emitted with `source_last = 1`, `source_payload_error = 4'hF` and `source_payload_last_be = 4'hF`.
  - `trunc_pulse` is 1 on the following cycle.
  - Go to DROP with `owner = n`.

DROP
- `sink[owner]_ready = 1`. The other sink's ready is 0.
- `source_valid` is 0.
- Beats are consumed and discarded until a beat with `last = 1` transfers, then go to IDLE.

General rules
- The non-granted sink is never acknowledged. Its valid may stay high indefinitely.
- A packet of exactly `MAX_BEATS` beats with `last` set on beat `MAX_BEATS` is not truncated.
- A sink dropping valid mid-packet causes no timeout. The grant is held.

## Timing
Reset values (asserting `sys_rst_n` low forces these immediately, including mid-packet)
- State IDLE, `beat_cnt` 0, `last_grant` 1, `owner` 0.
- `source_valid` 0, `sinkN_ready` 0, `grant` 00, `trunc_pulse` 0.
- A packet cut by reset is not completed. Downstream sees a truncated stream with no `last`.

Latency and throughput
- There is one bubble cycle per packet: a valid seen in IDLE produces `source_valid` on the next cycle.
- Inside a packet, data passes through with zero latency. Throughput is one beat per cycle while `source_ready` is 1.
- The cycle after a `last` transfer is always IDLE. The earliest next grant is therefore 2 cycles after the last beat.

Handshake rules
- `source_valid` follows the granted `sinkn_valid` combinationally.
- `source_ready` low stalls the sink with no loss. The payload stays stable as long as the sink obeys stream rules.
- `grant` is registered and is 1 in GRANTn only.

Counter
- `beat_cnt` saturates logically at `MAX_BEATS-1`. It never wraps within a packet.

## Test plan
- **Reset behaviour:** hold `sys_rst_n` low with `source_ready = 1` and both sinks valid.
  - While in reset: all readies are 0, `source_valid` is 0 and `grant` is 00.
  - After release, with both sinks still valid: port 0 is granted first.
- **Alternation:** both sinks present continuous 3-beat packets (data 0xA0.., 0xB0..). Required source sequence: A, A, A, gap, B, B, B, gap, A…
  - `source_first` is 1 on each beat 0.
  - `source_last` is 1 on each beat 2.
- **Backpressure:** toggle `source_ready` 1/0 every cycle during a 4-beat packet from sink1.
  - No beat is lost or duplicated.
  - `sink1_ready` mirrors `source_ready`.
  - `sink0_ready` stays 0 throughout.
- **Truncation:** `MAX_BEATS = 4`, sink0 sends a 7-beat packet.
  - Beat 4 is output with `last = 1` and `error = 4'hF`.
  - `trunc_pulse` is 1 for one cycle.
  - Beats 5–7 are absorbed with `source_valid = 0`, then the state returns to IDLE.
- **Boundary length:** `MAX_BEATS = 4`, sink1 sends exactly 4 beats with `last` on beat 4.
  - No truncation occurs: error passes through as 0 and `trunc_pulse` stays 0.
- **Reset mid-packet:** assert `sys_rst_n` during beat 2 of a 5-beat packet from sink0, while sink1 is valid.
  - `source_valid` drops to 0 immediately.
  - After release, port 0 wins the tie again, because `last_grant` has reset to 1.
